// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I pipeline: next-PC select encoding,
// the canonical NOP word and the default reset vector.
package cpu_pkg;

    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_JALR   = 2'b10
    } pcsrc_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble on flush, hold on stall, else capture
// the fetched word together with its PC and PC+4.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic [DATAWIDTH-1:0] instr_i,
    input  logic [DATAWIDTH-1:0] pc_i,
    input  logic [DATAWIDTH-1:0] pc_plus4_i,
    output logic [DATAWIDTH-1:0] instr_o,
    output logic [DATAWIDTH-1:0] pc_o,
    output logic [DATAWIDTH-1:0] pc_plus4_o,
    output logic                 valid_o
);

    logic [DATAWIDTH-1:0] instr_q, instr_d;
    logic [DATAWIDTH-1:0] pc_q, pc_d;
    logic [DATAWIDTH-1:0] pc_plus4_q, pc_plus4_d;
    logic                 valid_q, valid_d;

    // NOTE: every _d gets a default (hold) first so no path leaves it unassigned and infers a latch.
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush_i) begin
            instr_d    = DATAWIDTH'(NOP_INSTR);
            pc_d       = '0;
            pc_plus4_d = '0;
            valid_d    = 1'b0;
        end else if (!stall_i) begin
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q    <= DATAWIDTH'(NOP_INSTR);
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register with branch/JALR redirect, sticky
// misaligned-target flag, and the IF/ID register feeding decode.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                   DATAWIDTH = 32,
    parameter logic [DATAWIDTH-1:0] RESET_PC  = DATAWIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 Stall_i,
    input  logic                 Flush_i,
    input  logic [1:0]           PCSrc_i,
    input  logic [DATAWIDTH-1:0] PCE_i,
    input  logic [DATAWIDTH-1:0] ImmExtE_i,
    input  logic [DATAWIDTH-1:0] AluResultE_i,
    output logic [DATAWIDTH-1:0] InstrAddr_o,
    input  logic [DATAWIDTH-1:0] InstrData_i,
    output logic [DATAWIDTH-1:0] InstrD_o,
    output logic [DATAWIDTH-1:0] PCD_o,
    output logic [DATAWIDTH-1:0] PCPlus4D_o,
    output logic                 ValidD_o,
    output logic                 MisalignErr_o
);

    logic [DATAWIDTH-1:0] pcf_q, pcf_d;
    logic [DATAWIDTH-1:0] pc_plus4_f;
    logic [DATAWIDTH-1:0] target;
    logic                 redirect;
    logic                 misalign_q, misalign_d;

    always_comb begin
        pc_plus4_f = pcf_q + DATAWIDTH'(4);
        redirect   = 1'b0;
        target     = pc_plus4_f;
        case (PCSrc_i)
            PCSRC_BRANCH: begin
                redirect = 1'b1;
                target   = PCE_i + ImmExtE_i;
            end
            PCSRC_JALR: begin
                redirect = 1'b1;
                target   = AluResultE_i & ~DATAWIDTH'(1);
            end
            default: ;  // the reserved encoding falls through as sequential fetch
        endcase

        pcf_d = pcf_q;
        if (redirect) begin
            pcf_d = {target[DATAWIDTH-1:2], 2'b00};
        end else if (!Stall_i) begin
            pcf_d = pc_plus4_f;
        end

        misalign_d = misalign_q | (redirect && (target[1:0] != 2'b00));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcf_q      <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pcf_q      <= pcf_d;
            misalign_q <= misalign_d;
        end
    end

    assign InstrAddr_o   = pcf_q;
    assign MisalignErr_o = misalign_q;

    // A redirect squashes whatever is being fetched this cycle.
    if_id_reg #(
        .DATAWIDTH(DATAWIDTH)
    ) u_if_id_reg (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .stall_i    (Stall_i),
        .flush_i    (Flush_i | redirect),
        .instr_i    (InstrData_i),
        .pc_i       (pcf_q),
        .pc_plus4_i (pc_plus4_f),
        .instr_o    (InstrD_o),
        .pc_o       (PCD_o),
        .pc_plus4_o (PCPlus4D_o),
        .valid_o    (ValidD_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model predicts the
// post-edge state, and a negedge monitor compares it with the DUT outputs.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, Stall_i, Flush_i;
    logic [1:0]  PCSrc_i;
    logic [31:0] PCE_i, ImmExtE_i, AluResultE_i;
    logic [31:0] InstrAddr_o, InstrData_i, InstrD_o, PCD_o, PCPlus4D_o;
    logic        ValidD_o, MisalignErr_o;

    always #5 clk_i = ~clk_i;

    fetch_stage #(
        .DATAWIDTH(32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .Stall_i      (Stall_i),
        .Flush_i      (Flush_i),
        .PCSrc_i      (PCSrc_i),
        .PCE_i        (PCE_i),
        .ImmExtE_i    (ImmExtE_i),
        .AluResultE_i (AluResultE_i),
        .InstrAddr_o  (InstrAddr_o),
        .InstrData_i  (InstrData_i),
        .InstrD_o     (InstrD_o),
        .PCD_o        (PCD_o),
        .PCPlus4D_o   (PCPlus4D_o),
        .ValidD_o     (ValidD_o),
        .MisalignErr_o(MisalignErr_o)
    );

    // Instruction memory: each word is a fixed scramble of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction
    assign InstrData_i = mem_word(InstrAddr_o);

    typedef struct packed {
        logic [31:0] pcf;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pcp4;
        logic        valid;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    task automatic model_bubble();
        m.instr = NOP_INSTR;
        m.pcd   = 32'd0;
        m.pcp4  = 32'd0;
        m.valid = 1'b0;
    endtask

    // Behavioural next-state: what the fetch stage should look like after the edge.
    task automatic model_step(input logic rst, input logic stall, input logic flush,
                              input logic [1:0] src, input logic [31:0] pce,
                              input logic [31:0] imm, input logic [31:0] alu);
        longint unsigned tgt;
        if (rst) begin
            m.pcf = 32'd0;
            m.err = 1'b0;
            model_bubble();
        end else if (src == 2'd1 || src == 2'd2) begin
            if (src == 2'd1) tgt = (longint'(pce) + longint'(imm)) % 64'h1_0000_0000;
            else             tgt = longint'(alu) - (longint'(alu) % 2);
            if (tgt % 4 != 0) m.err = 1'b1;
            m.pcf = 32'(tgt - (tgt % 4));
            model_bubble();
        end else begin
            if (flush) model_bubble();
            else if (!stall) begin
                m.instr = mem_word(m.pcf);
                m.pcd   = m.pcf;
                m.pcp4  = 32'((longint'(m.pcf) + 4) % 64'h1_0000_0000);
                m.valid = 1'b1;
            end
            if (!stall) m.pcf = 32'((longint'(m.pcf) + 4) % 64'h1_0000_0000);
        end
    endtask

    // Drive one cycle; returns 1 time unit after the edge.
    task automatic step(input logic rst, input logic stall, input logic flush,
                        input logic [1:0] src, input logic [31:0] pce,
                        input logic [31:0] imm, input logic [31:0] alu);
        rst_i = rst; Stall_i = stall; Flush_i = flush;
        PCSrc_i = src; PCE_i = pce; ImmExtE_i = imm; AluResultE_i = alu;
        model_step(rst, stall, flush, src, pce, imm, alu);
        @(posedge clk_i);
        exp_q.push_back(m);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
    endtask

    // Monitor: registered outputs are stable at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("InstrAddr_o",   InstrAddr_o,   e.pcf);
                check("InstrD_o",      InstrD_o,      e.instr);
                check("PCD_o",         PCD_o,         e.pcd);
                check("PCPlus4D_o",    PCPlus4D_o,    e.pcp4);
                check("ValidD_o",      32'(ValidD_o), 32'(e.valid));
                check("MisalignErr_o", 32'(MisalignErr_o), 32'(e.err));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m = '0;
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
        check("reset_pc", InstrAddr_o, 32'h0);
        check("reset_instr", InstrD_o, 32'h0000_0013);

        // Free run from reset
        idle();
        check("free_addr4", InstrAddr_o, 32'h4);
        check("free_valid", 32'(ValidD_o), 32'd1);
        idle();
        check("free_addr8", InstrAddr_o, 32'h8);
        check("free_pcd4", PCD_o, 32'h4);

        // Stall two cycles at PCF=8
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
        check("stall_addr", InstrAddr_o, 32'h8);
        check("stall_pcd", PCD_o, 32'h4);
        idle();
        check("resume_pcd", PCD_o, 32'h8);

        // Branch 0x20 + (-16)
        step(1'b0, 1'b0, 1'b0, 2'd1, 32'h20, 32'hFFFF_FFF0, 32'd0);
        check("br_addr", InstrAddr_o, 32'h10);
        check("br_bubble", 32'(ValidD_o), 32'd0);
        idle();
        check("br_pcd", PCD_o, 32'h10);

        // Misaligned JALR target sets sticky error
        step(1'b0, 1'b0, 1'b0, 2'd2, 32'd0, 32'd0, 32'h103);
        check("jalr_addr", InstrAddr_o, 32'h100);
        check("jalr_err", 32'(MisalignErr_o), 32'd1);
        idle();
        idle();

        // Stall+flush, then redirect under stall
        step(1'b0, 1'b1, 1'b1, 2'd0, 32'd0, 32'd0, 32'd0);
        check("sf_hold_addr", InstrAddr_o, 32'h108);
        check("sf_nop", InstrD_o, 32'h0000_0013);
        step(1'b0, 1'b1, 1'b0, 2'd1, 32'h40, 32'h8, 32'd0);
        check("stall_redirect", InstrAddr_o, 32'h48);
        idle();

        // Reset during a stalled redirect
        step(1'b1, 1'b1, 1'b0, 2'd2, 32'd0, 32'd0, 32'h207);
        check("rst_addr", InstrAddr_o, 32'h0);
        check("rst_err", 32'(MisalignErr_o), 32'd0);
        step(1'b0, 1'b0, 1'b0, 2'd2, 32'd0, 32'd0, 32'h101);
        check("jalr_aligned_addr", InstrAddr_o, 32'h100);
        check("jalr_aligned_err", 32'(MisalignErr_o), 32'd0);

        // PC+4 wrap-around; also the reserved select acts as PC+4
        step(1'b0, 1'b0, 1'b0, 2'd1, 32'hFFFF_FFF0, 32'hC, 32'd0);
        step(1'b0, 1'b0, 1'b0, 2'd3, 32'h40, 32'h40, 32'h40);
        check("wrap_addr", InstrAddr_o, 32'h0);
        check("wrap_pcp4", PCPlus4D_o, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [1:0] src;
            src = 2'($urandom_range(0, 7) < 5 ? 0 : $urandom_range(1, 3));
            step(1'($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 7) == 0),
                 src, $urandom(), $urandom(), $urandom());
        end

        idle();
        @(negedge clk_i);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
